// File: rtl/sim_ctrl_arb_pkg.sv
// Shared types and constants for the simulator-control arbiter.
// Word offsets index addr[9:2] of the device port.
package sim_ctrl_arb_pkg;

    localparam logic [7:0] CHAR_OUT_ADDR = 8'h0;
    localparam logic [7:0] SIM_CTRL_ADDR = 8'h2;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dev_req_t;

    // Host index visited at scan offset off, starting from base.
    function automatic int unsigned rr_idx(
        input int unsigned base,
        input int unsigned off,
        input int unsigned n
    );
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/sim_ctrl_arb_if.sv
// Host-side and device-side bus bundle of the simulator-control arbiter.
// The slave view belongs to the arbiter, the master view to its environment.
interface sim_ctrl_arb_if #(
    parameter int NumHosts = 2
);

    logic [NumHosts-1:0]       host_req_i;
    logic [NumHosts-1:0]       host_we_i;
    logic [NumHosts-1:0][3:0]  host_be_i;
    logic [NumHosts-1:0][31:0] host_addr_i;
    logic [NumHosts-1:0][31:0] host_wdata_i;
    logic [NumHosts-1:0]       host_gnt_o;
    logic [NumHosts-1:0]       host_rvalid_o;
    logic [31:0]               host_rdata_o;

    logic                      dev_req_o;
    logic                      dev_we_o;
    logic [3:0]                dev_be_o;
    logic [31:0]               dev_addr_o;
    logic [31:0]               dev_wdata_o;
    logic                      dev_rvalid_i;
    logic [31:0]               dev_rdata_i;

    modport slave (
        input  host_req_i,
        input  host_we_i,
        input  host_be_i,
        input  host_addr_i,
        input  host_wdata_i,
        output host_gnt_o,
        output host_rvalid_o,
        output host_rdata_o,
        output dev_req_o,
        output dev_we_o,
        output dev_be_o,
        output dev_addr_o,
        output dev_wdata_o,
        input  dev_rvalid_i,
        input  dev_rdata_i
    );

    modport master (
        output host_req_i,
        output host_we_i,
        output host_be_i,
        output host_addr_i,
        output host_wdata_i,
        input  host_gnt_o,
        input  host_rvalid_o,
        input  host_rdata_o,
        input  dev_req_o,
        input  dev_we_o,
        input  dev_be_o,
        input  dev_addr_o,
        input  dev_wdata_o,
        output dev_rvalid_i,
        output dev_rdata_i
    );

endinterface

// File: rtl/sim_ctrl_arb_idfifo.sv
// In-flight host ID FIFO; remembers who was granted so responses
// can be returned in issue order.
module sim_ctrl_arb_idfifo #(
    parameter int  Width = 1,
    parameter int  Depth = 2,
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [Width-1:0] data_i,
    input  logic            pop_i,
    output logic [Width-1:0] head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];

    // Guarded here too, so a misbehaving caller cannot corrupt the count.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/sim_ctrl_arbiter.sv
// Round-robin arbiter sharing the simulator-control device port
// between NumHosts requesters, with in-order response routing.
module sim_ctrl_arbiter #(
    parameter int  NumHosts       = 2,
    parameter int  MaxOutstanding = 2,
    localparam int HostIdW        = $clog2(NumHosts),
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    sim_ctrl_arb_if.slave bus,
    output logic          busy_o,
    output logic          err_o
);

    import sim_ctrl_arb_pkg::*;

    logic [HostIdW-1:0] rr_q;
    logic [HostIdW-1:0] win_idx;
    logic               found;
    logic               grant;
    dev_req_t           sel;

    logic [HostIdW-1:0] head;
    logic               full;
    logic               empty;
    logic [CntW-1:0]    count;
    logic               pop;
    logic               err_q;

    // Scan from rr_q upward; the first requester wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (!found &&
                bus.host_req_i[HostIdW'(rr_idx(32'(rr_q), i, NumHosts))]) begin
                found   = 1'b1;
                win_idx = HostIdW'(rr_idx(32'(rr_q), i, NumHosts));
            end
        end
    end

    // A full FIFO blocks the grant even when it pops this cycle.
    assign grant = found && !full;

    always_comb begin
        sel = '0;
        if (grant) begin
            sel.we    = bus.host_we_i[win_idx];
            sel.be    = bus.host_be_i[win_idx];
            sel.addr  = bus.host_addr_i[win_idx];
            sel.wdata = bus.host_wdata_i[win_idx];
        end
    end

    assign bus.host_gnt_o  = grant ? (NumHosts'(1) << win_idx) : '0;
    assign bus.dev_req_o   = grant;
    assign bus.dev_we_o    = sel.we;
    assign bus.dev_be_o    = sel.be;
    assign bus.dev_addr_o  = sel.addr;
    assign bus.dev_wdata_o = sel.wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (grant) begin
            rr_q <= (win_idx == HostIdW'(NumHosts - 1)) ?
                    '0 : win_idx + 1'b1;
        end
    end

    sim_ctrl_arb_idfifo #(
        .Width (HostIdW),
        .Depth (MaxOutstanding)
    ) u_idfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (win_idx),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign pop = bus.dev_rvalid_i && !empty;

    assign bus.host_rvalid_o = pop ? (NumHosts'(1) << head) : '0;
    assign bus.host_rdata_o  = pop ? bus.dev_rdata_i : '0;

    // A response with nothing in flight is a device protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (bus.dev_rvalid_i && empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_o  = err_q;
    assign busy_o = (count != '0);

endmodule

// File: tb/tb_sim_ctrl_arbiter.sv
// Directed bench for sim_ctrl_arbiter with two hosts and a
// switchable one-cycle echo device.
module tb_sim_ctrl_arbiter;

    import sim_ctrl_arb_pkg::*;

    logic clk;
    logic rst;
    logic busy;
    logic err;

    logic        auto_dev;
    logic        man_rv;
    logic [31:0] man_rd;
    logic        dev_req_q;
    logic [31:0] dev_wd_q;

    int vectors;
    int miscompares;
    int rv_cnt;
    logic [1:0] exp_g;
    logic [1:0] prev_g;

    sim_ctrl_arb_if #(.NumHosts(2)) bus ();

    sim_ctrl_arbiter #(
        .NumHosts       (2),
        .MaxOutstanding (2)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy),
        .err_o  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        dev_req_q <= bus.dev_req_o;
        dev_wd_q  <= bus.dev_wdata_o;
    end

    assign bus.dev_rvalid_i = auto_dev ? dev_req_q : man_rv;
    assign bus.dev_rdata_i  = auto_dev ? dev_wd_q : man_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rv_cnt      = 0;
        prev_g      = 2'b00;
        auto_dev    = 1'b0;
        man_rv      = 1'b0;
        man_rd      = '0;
        rst         = 1'b1;
        bus.host_req_i   = '0;
        bus.host_we_i    = '0;
        bus.host_be_i    = '0;
        bus.host_addr_i  = '0;
        bus.host_wdata_i = '0;

        // reset state
        tick();
        tick();
        settle();
        chk("rst_gnt", 32'(bus.host_gnt_o), 32'h0);
        chk("rst_rvalid", 32'(bus.host_rvalid_o), 32'h0);
        chk("rst_dreq", 32'(bus.dev_req_o), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // 1: single host1 char-out write
        rst      = 1'b0;
        auto_dev = 1'b1;
        tick();
        bus.host_req_i      = 2'b10;
        bus.host_we_i       = 2'b10;
        bus.host_be_i[1]    = 4'h1;
        bus.host_addr_i[1]  = {22'b0, CHAR_OUT_ADDR, 2'b00};
        bus.host_wdata_i[1] = 32'h41;
        settle();
        chk("t1_gnt", 32'(bus.host_gnt_o), 32'h2);
        chk("t1_dreq", 32'(bus.dev_req_o), 32'h1);
        chk("t1_daddr", bus.dev_addr_o, 32'h0);
        chk("t1_dwdata", bus.dev_wdata_o, 32'h41);
        chk("t1_dbe", 32'(bus.dev_be_o), 32'h1);
        chk("t1_dwe", 32'(bus.dev_we_o), 32'h1);
        tick();
        bus.host_req_i = 2'b00;
        settle();
        chk("t1_gnt_off", 32'(bus.host_gnt_o), 32'h0);
        chk("t1_rvalid", 32'(bus.host_rvalid_o), 32'h2);
        chk("t1_rdata", bus.host_rdata_o, 32'h41);
        chk("t1_err", 32'(err), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        tick();
        settle();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_rvalid", 32'(bus.host_rvalid_o), 32'h0);

        // 2: contention, alternating grants
        bus.host_req_i      = 2'b11;
        bus.host_we_i       = 2'b11;
        bus.host_be_i[0]    = 4'hf;
        bus.host_be_i[1]    = 4'hf;
        bus.host_addr_i[0]  = {22'b0, CHAR_OUT_ADDR, 2'b00};
        bus.host_addr_i[1]  = {22'b0, SIM_CTRL_ADDR, 2'b00};
        bus.host_wdata_i[0] = 32'ha0;
        bus.host_wdata_i[1] = 32'hb1;
        for (int i = 0; i < 6; i++) begin
            settle();
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("t2_gnt", 32'(bus.host_gnt_o), 32'(exp_g));
            chk("t2_daddr", bus.dev_addr_o,
                (i % 2 == 0) ? 32'h0 : 32'h8);
            chk("t2_rvalid", 32'(bus.host_rvalid_o),
                (i == 0) ? 32'h0 : 32'(prev_g));
            chk("t2_rdata", bus.host_rdata_o,
                (i == 0) ? 32'h0 :
                (prev_g == 2'b01) ? 32'ha0 : 32'hb1);
            prev_g = exp_g;
            tick();
        end
        bus.host_req_i = 2'b00;
        settle();
        chk("t2_last_rvalid", 32'(bus.host_rvalid_o), 32'h2);
        chk("t2_last_rdata", bus.host_rdata_o, 32'hb1);
        tick();

        // 3: full FIFO with a three-cycle device
        auto_dev = 1'b0;
        bus.host_req_i = 2'b11;
        settle();
        chk("t3_c0_gnt", 32'(bus.host_gnt_o), 32'h1);
        chk("t3_c0_busy", 32'(busy), 32'h0);
        tick();
        settle();
        chk("t3_c1_gnt", 32'(bus.host_gnt_o), 32'h2);
        chk("t3_c1_busy", 32'(busy), 32'h1);
        tick();
        bus.host_req_i = 2'b01;
        settle();
        chk("t3_c2_gnt", 32'(bus.host_gnt_o), 32'h0);
        chk("t3_c2_dreq", 32'(bus.dev_req_o), 32'h0);
        tick();
        man_rv = 1'b1;
        man_rd = 32'h33;
        settle();
        chk("t3_c3_gnt", 32'(bus.host_gnt_o), 32'h0);
        chk("t3_c3_rvalid", 32'(bus.host_rvalid_o), 32'h1);
        chk("t3_c3_rdata", bus.host_rdata_o, 32'h33);
        tick();
        man_rd = 32'h44;
        settle();
        chk("t3_c4_gnt", 32'(bus.host_gnt_o), 32'h1);
        chk("t3_c4_rvalid", 32'(bus.host_rvalid_o), 32'h2);
        chk("t3_c4_rdata", bus.host_rdata_o, 32'h44);
        tick();
        bus.host_req_i = 2'b00;
        man_rv = 1'b0;
        settle();
        chk("t3_c5_rvalid", 32'(bus.host_rvalid_o), 32'h0);
        chk("t3_c5_rdata", bus.host_rdata_o, 32'h0);
        chk("t3_c5_busy", 32'(busy), 32'h1);
        tick();
        tick();
        man_rv = 1'b1;
        man_rd = 32'h55;
        settle();
        chk("t3_c7_rvalid", 32'(bus.host_rvalid_o), 32'h1);
        chk("t3_c7_rdata", bus.host_rdata_o, 32'h55);
        tick();
        man_rv = 1'b0;
        settle();
        chk("t3_c8_busy", 32'(busy), 32'h0);

        // 4: stray response
        tick();
        man_rv = 1'b1;
        man_rd = 32'hdead;
        settle();
        chk("t4_rvalid", 32'(bus.host_rvalid_o), 32'h0);
        chk("t4_rdata", bus.host_rdata_o, 32'h0);
        chk("t4_err_pre", 32'(err), 32'h0);
        tick();
        man_rv = 1'b0;
        settle();
        chk("t4_err_set", 32'(err), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        tick();
        tick();
        settle();
        chk("t4_err_sticky", 32'(err), 32'h1);

        // 5: reset while a response is pending
        bus.host_req_i = 2'b01;
        settle();
        chk("t5_gnt", 32'(bus.host_gnt_o), 32'h1);
        tick();
        bus.host_req_i = 2'b00;
        rst = 1'b1;
        settle();
        chk("t5_busy_pre", 32'(busy), 32'h1);
        tick();
        rst = 1'b0;
        settle();
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_err_clr", 32'(err), 32'h0);
        chk("t5_rvalid", 32'(bus.host_rvalid_o), 32'h0);
        bus.host_req_i = 2'b11;
        settle();
        chk("t5_rr_reset", 32'(bus.host_gnt_o), 32'h1);
        tick();
        bus.host_req_i = 2'b00;
        man_rv = 1'b1;
        man_rd = 32'h77;
        settle();
        chk("t5_post_rvalid", 32'(bus.host_rvalid_o), 32'h1);
        chk("t5_post_rdata", bus.host_rdata_o, 32'h77);
        tick();
        man_rv = 1'b0;
        settle();
        chk("t5_post_busy", 32'(busy), 32'h0);

        // 6: back-to-back host0 traffic, push and pop together
        auto_dev = 1'b1;
        bus.host_req_i = 2'b01;
        for (int i = 0; i < 8; i++) begin
            bus.host_wdata_i[0] = 32'h100 + 32'(i);
            settle();
            chk("t6_gnt", 32'(bus.host_gnt_o), 32'h1);
            chk("t6_busy", 32'(busy), (i > 0) ? 32'h1 : 32'h0);
            if (bus.host_rvalid_o[0]) rv_cnt++;
            chk("t6_rvalid", 32'(bus.host_rvalid_o),
                (i > 0) ? 32'h1 : 32'h0);
            chk("t6_rdata", bus.host_rdata_o,
                (i > 0) ? 32'h100 + 32'(i - 1) : 32'h0);
            tick();
        end
        bus.host_req_i = 2'b00;
        settle();
        if (bus.host_rvalid_o[0]) rv_cnt++;
        chk("t6_last_rvalid", 32'(bus.host_rvalid_o), 32'h1);
        chk("t6_last_rdata", bus.host_rdata_o, 32'h107);
        chk("t6_last_busy", 32'(busy), 32'h1);
        tick();
        settle();
        chk("t6_rv_count", 32'(rv_cnt), 32'd8);
        chk("t6_idle_busy", 32'(busy), 32'h0);
        chk("t6_err", 32'(err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
